// File: rtl/conv_pkg.sv
// Shared types and limits for the serial magnitude converter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package conv_pkg;

    // Largest word width the converter supports.
    localparam int MAX_WIDTH = 32;

    // Control states of the bit-serial converter.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

endpackage

// File: rtl/one_bit_adder.sv
// Single-bit full adder, shared across bit positions by the serial converter.
// Latency: purely combinational.
// Backpressure: none.
module one_bit_adder (
    input  logic a,
    input  logic b,
    input  logic C_in,
    output logic C_out,
    output logic sum
);

    assign sum   = a ^ b ^ C_in;
    assign C_out = (a & b) | (a & C_in) | (b & C_in);

endmodule

// File: rtl/serial_abs_converter.sv
// Bit-serial two's-complement to magnitude converter built around one shared 1-bit adder.
// Latency: accept at edge T0, result valid after edge T0+WIDTH-1; one word per WIDTH+1 cycles best case.
// Backpressure: holds the result stable in DONE until out_ready; accepts new words only in IDLE.
module serial_abs_converter
    import conv_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

    localparam int            CW       = $clog2(WIDTH);
    // Index of the last low bit; the sign position is never processed.
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 2);

    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_width_check
        $error("serial_abs_converter: WIDTH %0d outside 2..%0d", WIDTH, MAX_WIDTH);
    end

    conv_state_e       state_q;
    conv_state_e       state_d;

    logic [WIDTH-1:0]  src_q;
    logic              sign_q;
    logic              carry_q;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  res_q;
    logic              ovf_q;

    logic              accept;
    logic              shift_en;
    logic              last_bit;
    logic              add_a;
    logic              add_sum;
    logic              add_cout;

    // Handshake strobes decode from the state register alone.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

    assign accept   = in_ready && in_valid;
    assign shift_en = (state_q == SHIFT);
    assign last_bit = shift_en && (cnt_q == LAST_IDX);

    // Conditional inversion of the current bit; the sign enters as the initial carry,
    // so the ripple forms ~x + 1 for negatives and x + 0 for non-negatives.
    assign add_a = src_q[cnt_q] ^ sign_q;

    one_bit_adder u_adder (
        .a     (add_a),
        .b     (1'b0),
        .C_in  (carry_q),
        .C_out (add_cout),
        .sum   (add_sum)
    );

    // The MSB of res_q is never written, so the magnitude's top bit is always zero.
    assign out_data = res_q;
    assign out_ovf  = ovf_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: accept in IDLE, ripple through low bits, hold result until taken.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: capture the word on accept, then produce one result bit per SHIFT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q   <= '0;
            sign_q  <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            src_q   <= in_data;
            sign_q  <= in_data[WIDTH-1];
            carry_q <= in_data[WIDTH-1];
            cnt_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (shift_en) begin
            res_q[cnt_q] <= add_sum;
            carry_q      <= add_cout;
            if (cnt_q == LAST_IDX) begin
                // A carry out of the last low bit only happens for the most-negative word.
                ovf_q <= add_cout;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_abs_converter.sv
// Scoreboard bench for serial_abs_converter at WIDTH=4 (directed) and WIDTH=8 (exhaustive sweep).
// Latency: expects results WIDTH-1 edges after accept.
// Backpressure: exercises held out_ready and random downstream stalls.
module tb_serial_abs_converter;

    typedef struct {
        logic [31:0] d;
        logic        ovf;
        int          t;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       in_valid4 = 1'b0;
    logic       in_ready4;
    logic [3:0] in_data4 = '0;
    logic       out_valid4;
    logic       out_ready4 = 1'b0;
    logic [3:0] out_data4;
    logic       out_ovf4;
    logic       busy4;

    logic       in_valid8 = 1'b0;
    logic       in_ready8;
    logic [7:0] in_data8 = '0;
    logic       out_valid8;
    logic       out_ready8 = 1'b1;
    logic [7:0] out_data8;
    logic       out_ovf8;
    logic       busy8;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    exp_t q4[$];
    exp_t q8[$];
    logic stall8 = 1'b0;
    logic seen4 = 1'b0, post4 = 1'b0;
    logic seen8 = 1'b0, post8 = 1'b0;

    serial_abs_converter #(.WIDTH(4)) u4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_data   (in_data4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_data  (out_data4),
        .out_ovf   (out_ovf4),
        .busy      (busy4)
    );

    serial_abs_converter #(.WIDTH(8)) u8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_data   (in_data8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_data  (out_data8),
        .out_ovf   (out_ovf8),
        .busy      (busy8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: magnitude of a w-bit two's-complement value, reduced mod 2^(w-1).
    function automatic exp_t model(input int w, input logic [31:0] x, input int t);
        exp_t   e;
        longint m;
        m = longint'(x);
        if (x[w-1]) begin
            m = ((longint'(1) << w) - m) % (longint'(1) << (w - 1));
        end
        e.d   = 32'(m);
        e.ovf = (x == 32'(longint'(1) << (w - 1)));
        e.t   = t;
        return e;
    endfunction

    task automatic send(input int w, input logic [31:0] d);
        int   n = 0;
        logic ok = 1'b0;
        @(posedge clk);
        #1;
        if (w == 4) begin
            in_valid4 = 1'b1;
            in_data4  = d[3:0];
        end else begin
            in_valid8 = 1'b1;
            in_data8  = d[7:0];
        end
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = (w == 4) ? in_ready4 : in_ready8;
            n++;
        end
        check($sformatf("u%0d_accept_0x%0h", w, d), 32'(ok), 1);
        if (ok) begin
            if (w == 4) q4.push_back(model(4, d, cyc + 1));
            else        q8.push_back(model(8, d, cyc + 1));
        end
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        in_valid8 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q4.size() != 0 || q8.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 32'(q4.size() + q8.size()), 0);
    endtask

    // Monitor for the 4-bit instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen4 = 1'b0;
            post4 = 1'b0;
        end else begin
            if (post4) begin
                check("u4_in_ready_after_done", 32'(in_ready4), 1);
                check("u4_busy_after_done", 32'(busy4), 0);
                post4 = 1'b0;
            end
            if (out_valid4) begin
                if (q4.size() == 0) begin
                    check("u4_unexpected_valid", 32'(out_valid4), 0);
                end else begin
                    if (!seen4) begin
                        check("u4_latency", 32'(cyc - q4[0].t), 3);
                        seen4 = 1'b1;
                    end
                    check("u4_data", 32'(out_data4), q4[0].d);
                    check("u4_ovf", 32'(out_ovf4), 32'(q4[0].ovf));
                    if (out_ready4) begin
                        void'(q4.pop_front());
                        seen4 = 1'b0;
                        post4 = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen8 = 1'b0;
            post8 = 1'b0;
        end else begin
            if (post8) begin
                check("u8_in_ready_after_done", 32'(in_ready8), 1);
                post8 = 1'b0;
            end
            if (out_valid8) begin
                if (q8.size() == 0) begin
                    check("u8_unexpected_valid", 32'(out_valid8), 0);
                end else begin
                    if (!seen8) begin
                        check("u8_latency", 32'(cyc - q8[0].t), 7);
                        seen8 = 1'b1;
                    end
                    check("u8_data", 32'(out_data8), q8[0].d);
                    check("u8_ovf", 32'(out_ovf8), 32'(q8[0].ovf));
                    if (out_ready8) begin
                        void'(q8.pop_front());
                        seen8 = 1'b0;
                        post8 = 1'b1;
                    end
                end
            end
        end
    end

    // Downstream stall generator for the 8-bit instance.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready8 = stall8 ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Global time limit.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset state of both instances.
        #1;
        check("rst_u4_in_ready", 32'(in_ready4), 1);
        check("rst_u4_out_valid", 32'(out_valid4), 0);
        check("rst_u4_out_data", 32'(out_data4), 0);
        check("rst_u4_out_ovf", 32'(out_ovf4), 0);
        check("rst_u4_busy", 32'(busy4), 0);
        check("rst_u8_in_ready", 32'(in_ready8), 1);
        check("rst_u8_out_valid", 32'(out_valid8), 0);
        check("rst_u8_out_data", 32'(out_data8), 0);
        check("rst_u8_busy", 32'(busy8), 0);
        #10;
        rst_n = 1'b1;

        // Directed 4-bit words with downstream always ready.
        out_ready4 = 1'b1;
        send(4, 32'b1011);
        drain();
        send(4, 32'b0110);
        send(4, 32'b1111);
        send(4, 32'b1000);
        drain();

        // Backpressure: result held while out_ready is low, input ignored.
        out_ready4 = 1'b0;
        send(4, 32'b1101);
        n = 0;
        while (!out_valid4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("u4_bp_valid_rise", 32'(out_valid4), 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid4 = ~in_valid4;
            in_data4  = 4'($urandom);
            @(negedge clk);
            check("u4_bp_valid_held", 32'(out_valid4), 1);
            check("u4_bp_in_ready_low", 32'(in_ready4), 0);
        end
        @(posedge clk);
        #1;
        in_valid4  = 1'b0;
        out_ready4 = 1'b1;
        drain();

        // Reset pulse in the middle of SHIFT discards the word.
        send(4, 32'b0101);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        q4.delete();
        check("midrst_u4_in_ready", 32'(in_ready4), 1);
        check("midrst_u4_out_valid", 32'(out_valid4), 0);
        check("midrst_u4_out_data", 32'(out_data4), 0);
        check("midrst_u4_out_ovf", 32'(out_ovf4), 0);
        check("midrst_u4_busy", 32'(busy4), 0);
        #3;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        send(4, 32'b1110);
        drain();

        // A few random 4-bit words.
        for (int i = 0; i < 8; i++) begin
            send(4, 32'($urandom_range(0, 15)));
        end
        drain();

        // Exhaustive 8-bit sweep with random downstream stalls and input gaps.
        stall8 = 1'b1;
        for (int v = 0; v < 256; v++) begin
            send(8, 32'(v));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain();
        stall8 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
